keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/scan_tick_gen.sv | 21 ++
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key code table for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_res_t;

    // Entry k = row*4 + col lives in bits [k*4 +: 4].
    localparam logic [63:0] KEY_TABLE = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code_of(input logic [3:0] key);
        return KEY_TABLE[{key, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// One-cycle tick every DIV clocks; paces the column scan.
module scan_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, ghost-rejecting scan, debounce FSM and
// a one-deep output holding register with sticky overrun.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);
    // CLK_HZ must be an integer multiple of SCAN_HZ with a ratio of at least 2.
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic       tick;
    logic [1:0] scan_col;
    logic [1:0] acc_hits, acc_r, acc_c;
    logic [3:0] low;
    logic [1:0] smp_r, smp_hits, sum_hits, pos_r, pos_c;
    logic [2:0] sum3;
    logic       scan_done;
    scan_res_t  scan_res;
    logic [3:0] scan_key;

    state_t           state, state_nx;
    logic [CNT_W-1:0] deb_cnt, cnt_nx, cnt_inc;
    logic [3:0]       cand, cand_nx;
    logic             accept;

    scan_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign col       = ~(4'b0001 << scan_col);
    assign scan_done = tick && (scan_col == 2'd3);

    // Hits saturate at 2: anything beyond one low row bit is already MULTI.
    always_comb begin
        low   = ~row;
        smp_r = '0;
        for (int i = 0; i < 4; i++)
            if (low[i]) smp_r = 2'(i);
        smp_hits = ($countones(low) > 1) ? 2'd2 : 2'($countones(low));
        sum3     = {1'b0, acc_hits} + {1'b0, smp_hits};
        sum_hits = (sum3 > 3'd2) ? 2'd2 : sum3[1:0];
        pos_r    = (acc_hits == 2'd0) ? smp_r    : acc_r;
        pos_c    = (acc_hits == 2'd0) ? scan_col : acc_c;
        scan_key = {pos_r, pos_c};
        case (sum_hits)
            2'd0:    scan_res = SCAN_NONE;
            2'd1:    scan_res = SCAN_SINGLE;
            default: scan_res = SCAN_MULTI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_col <= '0;
            acc_hits <= '0;
            acc_r    <= '0;
            acc_c    <= '0;
        end else if (tick) begin
            scan_col <= scan_col + 2'd1;
            if (scan_col == 2'd3) begin
                acc_hits <= '0;
            end else begin
                acc_hits <= sum_hits;
                acc_r    <= pos_r;
                acc_c    <= pos_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            deb_cnt <= '0;
            cand    <= '0;
        end else begin
            state   <= state_nx;
            deb_cnt <= cnt_nx;
            cand    <= cand_nx;
        end
    end

    // MULTI is handled exactly like NONE: only SCAN_SINGLE counts as a key.
    always_comb begin
        state_nx = state;
        cnt_nx   = deb_cnt;
        cand_nx  = cand;
        accept   = 1'b0;
        cnt_inc  = deb_cnt + CNT_ONE;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_res == SCAN_SINGLE) begin
                        cand_nx = scan_key;
                        if (CNT_ONE >= CNT_DONE) begin
                            accept   = 1'b1;
                            state_nx = HELD;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = DEB_PRESS;
                            cnt_nx   = CNT_ONE;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (scan_res == SCAN_SINGLE && scan_key == cand) begin
                        if (cnt_inc == CNT_DONE) begin
                            accept   = 1'b1;
                            state_nx = HELD;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                HELD: begin
                    if (scan_res != SCAN_SINGLE) begin
                        state_nx = (CNT_ONE >= CNT_DONE) ? IDLE : DEB_RELEASE;
                        cnt_nx   = (CNT_ONE >= CNT_DONE) ? '0 : CNT_ONE;
                    end
                end
                DEB_RELEASE: begin
                    if (scan_res == SCAN_SINGLE) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // An ack in the acceptance cycle frees the slot for the new key.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (accept && (!key_valid || key_ack)) begin
            key_code  <= key_code_of(cand);
            key_valid <= 1'b1;
        end else if (accept) begin
            overrun <= 1'b1;
        end else if (key_ack) begin
            key_valid <= 1'b0;
        end
    end

endmodule
